// File: rtl/dco_tune_arb.sv
// Round-robin sequencer for the shared DCO tuning-word write port.
// Each grant commits one write, then the port is held for a programmable settle time.
module dco_tune_arb #(
  parameter int unsigned N_REQ    = 6,
  parameter int unsigned DW       = 8,
  parameter int unsigned SETTLE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*DW-1:0]   wdata,
  input  logic [SETTLE_W-1:0]   settle_cyc,
  output logic [N_REQ-1:0]      gnt,
  output logic                  dco_we,
  output logic [DW-1:0]         dco_wdata,
  output logic                  idle
);

  localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if ((N_REQ < 2) || (N_REQ > 8)) begin : g_bad_n_req
    $error("dco_tune_arb: N_REQ must be in the range 2..8");
  end

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StSettle
  } state_e;

  state_e              state_q, state_d;
  logic [PtrW-1:0]     ptr_q, ptr_d;
  logic [PtrW-1:0]     win_q, win_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic                we_q, we_d;

  logic [PtrW-1:0]     pick;
  logic                pick_vld;

  // Scan downward so the lowest offset from ptr (highest priority) is written last.
  always_comb begin
    pick     = ptr_q;
    pick_vld = 1'b0;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      if (req[(int'(ptr_q) + k) % int'(N_REQ)]) begin
        pick     = PtrW'((int'(ptr_q) + k) % int'(N_REQ));
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    wdata_d = wdata_q;
    gnt_d   = '0;
    we_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pick_vld) begin
          win_d       = pick;
          wdata_d     = wdata[pick*DW +: DW];
          cnt_d       = settle_cyc;
          gnt_d[pick] = 1'b1;
          we_d        = 1'b1;
          state_d     = StWrite;
        end
      end
      StWrite: begin
        ptr_d   = (win_q == PtrW'(N_REQ - 1)) ? '0 : win_q + PtrW'(1);
        state_d = (cnt_q == '0) ? StIdle : StSettle;
      end
      StSettle: begin
        if (cnt_q <= SETTLE_W'(1)) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - SETTLE_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
      gnt_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
    end
  end

  assign gnt       = gnt_q;
  assign dco_we    = we_q;
  assign dco_wdata = wdata_q;
  assign idle      = (state_q == StIdle) && (req == '0);

  // The grant pulse and write strobe always travel together.
  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_we_gnt:     assert property (@(posedge clk) disable iff (!rst_n) dco_we == (gnt != '0));

endmodule

// File: tb/tb_dco_tune_arb.sv
// Scoreboard bench for dco_tune_arb: expected writes are queued with their cycle stamp
// when stimulus is applied and compared when the DUT strobes dco_we.
module tb_dco_tune_arb;

  localparam int unsigned N  = 6;
  localparam int unsigned DW = 8;
  localparam int unsigned SW = 4;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req;
  logic [N*DW-1:0]   wdata;
  logic [SW-1:0]     settle_cyc;
  logic [N-1:0]      gnt;
  logic              dco_we;
  logic [DW-1:0]     dco_wdata;
  logic              idle;

  dco_tune_arb #(
    .N_REQ    (N),
    .DW       (DW),
    .SETTLE_W (SW)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .wdata      (wdata),
    .settle_cyc (settle_cyc),
    .gnt        (gnt),
    .dco_we     (dco_we),
    .dco_wdata  (dco_wdata),
    .idle       (idle)
  );

  typedef struct {
    logic [N-1:0]  gnt;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   c, c2, c3;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int r, input logic [DW-1:0] d, input int at);
    exp_t e;
    e.gnt    = '0;
    e.gnt[r] = 1'b1;
    e.data   = d;
    e.cyc    = at;
    sb.push_back(e);
  endtask

  task automatic set_w(input int i, input logic [DW-1:0] v);
    wdata[i*DW +: DW] = v;
  endtask

  // Write monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (dco_we || (gnt != '0)) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_write", 32'(gnt), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("wr_gnt", 32'(gnt), 32'(mon_e.gnt));
        check_eq("wr_we", 32'(dco_we), 32'd1);
        check_eq("wr_data", 32'(dco_wdata), 32'(mon_e.data));
        check_eq("wr_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    req        = '0;
    wdata      = '0;
    settle_cyc = '0;

    // 1. Reset with random inputs
    for (int i = 0; i < 4; i++) begin
      req        = N'($urandom);
      wdata      = 48'({$urandom, $urandom});
      settle_cyc = SW'($urandom);
      step(1);
      check_eq("rst_gnt", 32'(gnt), 32'd0);
      check_eq("rst_we", 32'(dco_we), 32'd0);
      check_eq("rst_wdata", 32'(dco_wdata), 32'd0);
    end
    req = '0;
    #1;
    check_eq("rst_idle", 32'(idle), 32'd1);
    rst_n = 1'b1;
    step(3);
    check_eq("post_rst_we", 32'(dco_we), 32'd0);
    check_eq("post_rst_wdata", 32'(dco_wdata), 32'd0);
    check_eq("post_rst_idle", 32'(idle), 32'd1);

    // 2. Single request with settle = 3 (ptr 0 -> 3)
    wdata      = '0;
    settle_cyc = 4'd3;
    set_w(2, 8'h5A);
    req[2] = 1'b1;
    c = cyc;
    push(2, 8'h5A, c + 1);
    step(1);
    req[2] = 1'b0;
    step(3);
    check_eq("t2_settling", 32'(idle), 32'd0);
    step(1);
    check_eq("t2_idle", 32'(idle), 32'd1);
    check_eq("t2_hold", 32'(dco_wdata), 32'h5A);

    // 4. Pointer rotation: grant 3, then {1,5} -> 5 then 1, ptr ends at 2
    settle_cyc = 4'd0;
    set_w(3, 8'h33);
    req[3] = 1'b1;
    c = cyc;
    push(3, 8'h33, c + 1);
    step(1);
    req[3] = 1'b0;
    step(1);
    c2 = cyc;
    set_w(1, 8'h11);
    set_w(5, 8'h55);
    req[1] = 1'b1;
    req[5] = 1'b1;
    push(5, 8'h55, c2 + 1);
    push(1, 8'h11, c2 + 3);
    step(1);
    req[5] = 1'b0;
    step(2);
    req[1] = 1'b0;
    step(1);
    c3 = cyc;
    set_w(0, 8'hA0);
    set_w(2, 8'hA2);
    req[0] = 1'b1;
    req[2] = 1'b1;
    push(2, 8'hA2, c3 + 1);
    push(0, 8'hA0, c3 + 3);
    step(1);
    req[2] = 1'b0;
    step(2);
    req[0] = 1'b0;
    step(2);

    // 3. Full contention from ptr 0, no settle
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(1);
    for (int i = 0; i < int'(N); i++) set_w(i, 8'(8'hE0 + i));
    settle_cyc = 4'd0;
    c = cyc;
    req = '1;
    for (int i = 0; i <= int'(N); i++) push(i % int'(N), 8'(8'hE0 + (i % int'(N))), c + 1 + 2*i);
    step(13);
    req = '0;
    step(3);
    check_eq("t3_idle", 32'(idle), 32'd1);

    // 5. Settle captured at the sampling edge; late drop still writes
    settle_cyc = 4'd5;
    set_w(0, 8'hC3);
    req[0] = 1'b1;
    c = cyc;
    push(0, 8'hC3, c + 1);
    push(0, 8'h3C, c + 8);
    push(0, 8'h77, c + 11);
    step(2);
    set_w(0, 8'h3C);
    step(1);
    settle_cyc = 4'd1;
    step(6);
    set_w(0, 8'h77);
    step(2);
    req[0] = 1'b0;
    step(1);
    check_eq("t5_settling", 32'(idle), 32'd0);
    step(1);
    check_eq("t5_idle", 32'(idle), 32'd1);
    check_eq("t5_hold", 32'(dco_wdata), 32'h77);

    // 6. Reset mid-settle, then requesters {0,3} from ptr 0
    settle_cyc = 4'd6;
    set_w(4, 8'h4D);
    req[4] = 1'b1;
    c = cyc;
    push(4, 8'h4D, c + 1);
    step(1);
    req[4] = 1'b0;
    step(2);
    check_eq("t6_pre_idle", 32'(idle), 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_gnt", 32'(gnt), 32'd0);
    check_eq("t6_rst_we", 32'(dco_we), 32'd0);
    check_eq("t6_rst_wdata", 32'(dco_wdata), 32'd0);
    check_eq("t6_rst_idle", 32'(idle), 32'd1);
    settle_cyc = 4'd0;
    set_w(0, 8'h0F);
    set_w(3, 8'hF3);
    req[0] = 1'b1;
    req[3] = 1'b1;
    step(1);
    rst_n = 1'b1;
    c = cyc;
    push(0, 8'h0F, c + 1);
    push(3, 8'hF3, c + 3);
    step(1);
    req[0] = 1'b0;
    step(2);
    req[3] = 1'b0;
    step(3);
    check_eq("t6_idle", 32'(idle), 32'd1);

    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
